// File: rtl/ctrl_uart_rx.sv
// ctrl_uart_rx: 8N1 UART receiver feeding a show-ahead byte FIFO; optional 8E1 mode under `CTRL_UART_RX_PARITY_EN.
// Latency: rx_valid rises 1 clk after the stop-bit sample, about 2 + 9.5*16*BAUD_DIV clk after the start edge.
// Backpressure: rx_valid/rx_ready pops the head; a byte arriving while the FIFO is full is dropped and ovr_err set.
module ctrl_uart_rx #(
  parameter int BAUD_DIV = 27,
  parameter int FIFO_AW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  output logic [7:0]       rx_dat,
  output logic             rx_valid,
  input  logic             rx_ready,
  input  logic             err_clr,
  output logic             frm_err,
  output logic             ovr_err,
`ifdef CTRL_UART_RX_PARITY_EN
  output logic             par_err,
`endif
  output logic             rx_busy,
  output logic [FIFO_AW:0] fifo_lvl
);

  localparam int                DEPTH    = 1 << FIFO_AW;
  localparam logic [11:0]       DIV_LAST = 12'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0]  FULL_LVL = (FIFO_AW + 1)'(DEPTH);

`ifdef CTRL_UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} state_t;
`endif

  state_t             state, state_nxt;
  logic               rxd_m, rxd_s;
  logic [11:0]        div_cnt;
  logic [3:0]         os_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         sreg;
  logic               tick, mid_bit, cnt_clr;
  logic               os_clr, bit_clr, shift_en, push_set, frm_set, push_q;
  logic               par_bad;
`ifdef CTRL_UART_RX_PARITY_EN
  logic               par_set;
`endif

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, pop, push_ok, ovr_set;

  assign tick    = (div_cnt == DIV_LAST);
  assign mid_bit = tick && (os_cnt == 4'd15);
  assign cnt_clr = (state == S_IDLE) || (state == S_WAIT);

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Baud divider and 16x oversample counter; held at zero so a frame always starts from 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else if (cnt_clr) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else begin
      div_cnt <= tick ? 12'd0 : div_cnt + 12'd1;
      if (tick) os_cnt <= os_clr ? 4'd0 : os_cnt + 4'd1;
    end
  end

  // State register plus the registered push request into the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      push_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      push_q <= push_set;
    end
  end

  // Frame decoder: start-bit validation at mid-bit, data and stop sampled at the end of each 16-tick bit
  always_comb begin
    state_nxt = state;
    os_clr    = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    push_set  = 1'b0;
    frm_set   = 1'b0;
`ifdef CTRL_UART_RX_PARITY_EN
    par_set   = 1'b0;
`endif
    unique case (state)
      S_IDLE:  if (!rxd_s) state_nxt = S_START;
      S_START: begin
        if (tick && os_cnt == 4'd7) begin
          if (!rxd_s) begin
            os_clr    = 1'b1;
            bit_clr   = 1'b1;
            state_nxt = S_DATA;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (mid_bit) begin
          shift_en = 1'b1;
`ifdef CTRL_UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state_nxt = S_PAR;
`else
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
`endif
        end
      end
`ifdef CTRL_UART_RX_PARITY_EN
      S_PAR: begin
        if (mid_bit) begin
          par_set   = rxd_s ^ (^sreg);
          state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (mid_bit) begin
          if (rxd_s) begin
            push_set  = !par_bad;
            state_nxt = S_IDLE;
          end else begin
            frm_set   = 1'b1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT:  if (rxd_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Data-bit counter and LSB-first shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      sreg    <= '0;
    end else begin
      if (bit_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) sreg <= {rxd_s, sreg[7:1]};
    end
  end

`ifdef CTRL_UART_RX_PARITY_EN
  // Parity mismatch blocks the push at STOP; par_err is sticky and a set beats err_clr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (bit_clr)      par_bad <= 1'b0;
      else if (par_set) par_bad <= 1'b1;
      if (par_set)      par_err <= 1'b1;
      else if (err_clr) par_err <= 1'b0;
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  assign full     = (count == FULL_LVL);
  assign pop      = rx_valid & rx_ready;
  assign push_ok  = push_q & (~full | pop);
  assign ovr_set  = push_q & full & ~pop;
  assign rx_valid = (count != '0);
  assign rx_dat   = mem[rd_ptr];
  assign fifo_lvl = count;
  assign rx_busy  = (state != S_IDLE);

  // Circular show-ahead FIFO; pointers wrap naturally at FIFO_AW bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= sreg;
        wr_ptr      <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      if (frm_set)      frm_err <= 1'b1;
      else if (err_clr) frm_err <= 1'b0;
      if (ovr_set)      ovr_err <= 1'b1;
      else if (err_clr) ovr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ctrl_uart_rx.sv
// tb_ctrl_uart_rx: bench for ctrl_uart_rx with directed frames followed by randomized traffic.
// Latency: push window is the final bit of each frame; model updates when that bit ends.
// Backpressure: rx_ready is random outside the push window, forced low inside it.
module tb_ctrl_uart_rx;
  localparam int BAUD_DIV = 4;
  localparam int FIFO_AW  = 2;
  localparam int DEPTH    = 4;
  localparam int BIT_CLK  = 16 * BAUD_DIV;
`ifdef CTRL_UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1, rx_ready = 1'b0, err_clr = 1'b0;
  logic [7:0] rx_dat;
  logic rx_valid, frm_err, ovr_err, rx_busy;
  logic [FIFO_AW:0] fifo_lvl;
`ifdef CTRL_UART_RX_PARITY_EN
  logic par_err;
`endif

  int errors = 0, checks = 0;
  int cyc = 0, t_start = 0, rise_cyc = 0;
  logic win = 1'b0, rand_en = 1'b0, rdy_dir = 1'b0, v_prev = 1'b0;
  int ev_q[$];                 // frame outcomes: byte pushed (0<<8|b), framing (1<<8), parity (2<<8)
  logic [7:0] m_q[$];
  logic m_frm = 1'b0, m_ovr = 1'b0, m_par = 1'b0;

  ctrl_uart_rx #(.BAUD_DIV(BAUD_DIV), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rx_dat(rx_dat), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .err_clr(err_clr), .frm_err(frm_err), .ovr_err(ovr_err),
`ifdef CTRL_UART_RX_PARITY_EN
    .par_err(par_err),
`endif
    .rx_busy(rx_busy), .fifo_lvl(fifo_lvl)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // consumer handshake driver
  initial forever begin
    @(posedge clk);
    #2;
    rx_ready = rdy_dir | (rand_en & ~win & ($urandom_range(0, 1) == 1));
  end

  // rising-edge recorder for rx_valid latency
  initial forever begin
    @(negedge clk);
    if (rx_valid && !v_prev) rise_cyc = cyc;
    v_prev = rx_valid;
  end

  // reference model and per-cycle comparison
  initial begin : cmp
    int ev_rd;
    int e;
    ev_rd = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_q.delete();
        m_frm = 1'b0; m_ovr = 1'b0; m_par = 1'b0;
        ev_rd = ev_q.size();
      end else begin
        while (ev_rd < ev_q.size()) begin
          e = ev_q[ev_rd];
          ev_rd++;
          case (e >> 8)
            0: if (m_q.size() < DEPTH) m_q.push_back(e[7:0]); else m_ovr = 1'b1;
            1: m_frm = 1'b1;
            default: m_par = 1'b1;
          endcase
        end
        if (!win) begin
          chk("model_fifo_lvl", int'(fifo_lvl), m_q.size());
          chk("model_rx_valid", int'(rx_valid), int'(m_q.size() != 0));
          if (m_q.size() != 0) chk("model_rx_dat", int'(rx_dat), int'(m_q[0]));
          chk("model_frm_err", int'(frm_err), int'(m_frm));
          chk("model_ovr_err", int'(ovr_err), int'(m_ovr));
`ifdef CTRL_UART_RX_PARITY_EN
          chk("model_par_err", int'(par_err), int'(m_par));
`endif
        end
        if (rx_ready && m_q.size() != 0) void'(m_q.pop_front());
        if (err_clr) begin m_frm = 1'b0; m_ovr = 1'b0; m_par = 1'b0; end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    wait_clk(BIT_CLK);
  endtask

  // One frame: start, 8 data LSB-first, optional even parity (flipped on request), stop
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    logic pbad;
    pbad = (PB == 1) && par_flip;
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    win = 1'b1;
    if (PB == 1) drive_bit((^b) ^ par_flip);
    drive_bit(stop);
    if (pbad) ev_q.push_back(2 << 8);
    if (!stop) ev_q.push_back(1 << 8);
    else if (!pbad) ev_q.push_back(int'(b));
    win = 1'b0;
  endtask

  task automatic pop_one();
    rdy_dir = 1'b1;
    wait_clk(1);
    rdy_dir = 1'b0;
    wait_clk(1);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    wait_clk(1);
    err_clr = 1'b0;
    wait_clk(1);
  endtask

  initial begin
    int lat;
    logic [7:0] b;
    wait_clk(3);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_fifo_lvl", int'(fifo_lvl), 0);
    chk("rst_rx_dat", int'(rx_dat), 0);
    chk("rst_frm_err", int'(frm_err), 0);
    chk("rst_ovr_err", int'(ovr_err), 0);
    chk("rst_rx_busy", int'(rx_busy), 0);
    rst = 1'b0;
    wait_clk(5);

    // 1: single frame, latency and pop
    send_frame(8'h55, 1'b1, 1'b0);
    lat = rise_cyc - t_start;
    chk("t1_latency_in_window", int'(lat >= 612 + 64 * PB && lat <= 620 + 64 * PB), 1);
    chk("t1_rx_dat", int'(rx_dat), 8'h55);
    chk("t1_fifo_lvl", int'(fifo_lvl), 1);
    pop_one();
    chk("t1_rx_valid_after_pop", int'(rx_valid), 0);
    chk("t1_fifo_lvl_after_pop", int'(fifo_lvl), 0);

    // 2: short low glitch
    rxd = 1'b0;
    wait_clk(20);
    chk("t2_busy_in_glitch", int'(rx_busy), 1);
    rxd = 1'b1;
    wait_clk(20);
    chk("t2_busy_after_glitch", int'(rx_busy), 0);
    chk("t2_frm_err", int'(frm_err), 0);
    chk("t2_fifo_lvl", int'(fifo_lvl), 0);

    // 3: framing error with line held low, recovery, err_clr
    send_frame(8'hA3, 1'b0, 1'b0);
    wait_clk(200);
    chk("t3_frm_err", int'(frm_err), 1);
    chk("t3_fifo_lvl", int'(fifo_lvl), 0);
    chk("t3_busy_line_low", int'(rx_busy), 1);
    rxd = 1'b1;
    wait_clk(BIT_CLK);
    chk("t3_busy_after_rise", int'(rx_busy), 0);
    send_frame(8'h12, 1'b1, 1'b0);
    chk("t3_rx_dat_next", int'(rx_dat), 8'h12);
    pop_one();
    pulse_clr();
    chk("t3_frm_err_cleared", int'(frm_err), 0);

    // 4: overrun with rx_ready held low, then drain in order
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    chk("t4_fifo_lvl_full", int'(fifo_lvl), 4);
    chk("t4_ovr_err", int'(ovr_err), 1);
    for (int i = 1; i <= 4; i++) begin
      chk("t4_drain_rx_dat", int'(rx_dat), i);
      pop_one();
    end
    chk("t4_rx_valid_empty", int'(rx_valid), 0);

    // 5: reset mid-frame with a byte queued and ovr_err still set
    send_frame(8'h77, 1'b1, 1'b0);
    rxd = 1'b0;
    wait_clk(BIT_CLK);
    rxd = 1'b1;
    wait_clk(3 * BIT_CLK + BIT_CLK / 2);
    rst = 1'b1;
    #1;
    chk("t5_rx_valid", int'(rx_valid), 0);
    chk("t5_fifo_lvl", int'(fifo_lvl), 0);
    chk("t5_rx_dat", int'(rx_dat), 0);
    chk("t5_ovr_err", int'(ovr_err), 0);
    chk("t5_frm_err", int'(frm_err), 0);
    chk("t5_rx_busy", int'(rx_busy), 0);
    wait_clk(3);
    rst = 1'b0;
    wait_clk(10);
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("t5_rx_dat_after", int'(rx_dat), 8'h3C);
    chk("t5_frm_err_after", int'(frm_err), 0);
    pop_one();

`ifdef CTRL_UART_RX_PARITY_EN
    // 6: even parity accept / reject
    send_frame(8'h07, 1'b1, 1'b0);
    chk("t6_par_ok_par_err", int'(par_err), 0);
    chk("t6_par_ok_rx_dat", int'(rx_dat), 8'h07);
    pop_one();
    send_frame(8'h07, 1'b1, 1'b1);
    chk("t6_par_bad_par_err", int'(par_err), 1);
    chk("t6_par_bad_fifo_lvl", int'(fifo_lvl), 0);
    pulse_clr();
`endif

    // randomized traffic against the model
    rand_en = 1'b1;
    for (int n = 0; n < 25; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      b = 8'($urandom_range(0, 255));
      if (kind < 7) begin
        send_frame(b, 1'b1, ($urandom_range(0, 7) == 0));
      end else if (kind < 9) begin
        send_frame(b, 1'b0, 1'b0);
        rxd = 1'b1;
        wait_clk(BIT_CLK);
      end else begin
        rxd = 1'b0;
        wait_clk($urandom_range(2, 20));
        rxd = 1'b1;
        wait_clk(48);
      end
      wait_clk($urandom_range(0, 60));
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end
    wait_clk(200);
    rand_en = 1'b0;
    wait_clk(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
